press_classifier: RTL and testbench

Downstream consumer of the debounced button level. It classifies each press into one of three events: short press, long press or double click. Each event is emitted as a single-cycle pulse, and a held-level flag is asserted during long presses. It sits between the debouncer instance and user logic (mode select, counters, display control) at the board top level.

---
 rtl/press_classifier_pkg.sv | 29 ++
 rtl/press_classifier.sv | 108 ++++++++++
 tb/tb_press_classifier.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/press_classifier_pkg.sv
// Shared definitions for the button press classifier: state encoding,
// board-clock defaults and the per-edge event payload.
package press_classifier_pkg;

  // State encoding, kept as plain constants for compatibility with older users
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] WAIT_GAP  = 3'd2;
  localparam logic [2:0] PRESS2    = 3'd3;
  localparam logic [2:0] LONG_HOLD = 3'd4;

  // Defaults for the 50 MHz board clock: 1 s long press, 250 ms double-click gap
  localparam int unsigned CNT_W_DEFAULT    = 26;
  localparam int unsigned LONG_CNT_DEFAULT = 50_000_000;
  localparam int unsigned GAP_CNT_DEFAULT  = 12_500_000;

  localparam int unsigned EVT_CNT_W = 8;

  typedef struct packed {
    logic short_ev;
    logic long_ev;
    logic double_ev;
  } press_evt_t;

  function automatic logic evt_any(input press_evt_t evt);
    return evt.short_ev | evt.long_ev | evt.double_ev;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button presses into short, long and double-click
// events; one shared interval counter serves both the long and gap timers.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned CntW    = CNT_W_DEFAULT,
  parameter int unsigned LongCnt = LONG_CNT_DEFAULT,
  parameter int unsigned GapCnt  = GAP_CNT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 level_i,
  output logic                 short_o,
  output logic                 long_o,
  output logic                 double_o,
  output logic                 held_o,
  output logic [EVT_CNT_W-1:0] event_cnt_o
);

  localparam logic [CntW-1:0] LAST_LONG = CntW'(LongCnt - 1);
  localparam logic [CntW-1:0] LAST_GAP  = CntW'(GapCnt - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  press_evt_t      evt_d;

  // State and interval counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and event decode; counter clears on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = '0;
    case (state_q)
      IDLE: begin
        if (level_i) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (!level_i) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LAST_LONG) begin
          state_d       = LONG_HOLD;
          cnt_d         = '0;
          evt_d.long_ev = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_GAP: begin
        // A press on the expiry edge still counts as a double click
        if (level_i) begin
          state_d         = PRESS2;
          cnt_d           = '0;
          evt_d.double_ev = 1'b1;
        end else if (cnt_q == LAST_GAP) begin
          state_d        = IDLE;
          cnt_d          = '0;
          evt_d.short_ev = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      PRESS2, LONG_HOLD: begin
        if (!level_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered pulses, hold flag and wrapping event counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      short_o     <= 1'b0;
      long_o      <= 1'b0;
      double_o    <= 1'b0;
      held_o      <= 1'b0;
      event_cnt_o <= '0;
    end else begin
      short_o  <= evt_d.short_ev;
      long_o   <= evt_d.long_ev;
      double_o <= evt_d.double_ev;
      held_o   <= (state_d == LONG_HOLD);
      if (evt_any(evt_d)) begin
        event_cnt_o <= event_cnt_o + EVT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LongCnt=8, GapCnt=5, CntW=4.
module tb_press_classifier;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       level_i;
  logic       short_o, long_o, double_o, held_o;
  logic [7:0] event_cnt_o;

  int errors = 0;
  int checks = 0;

  press_classifier #(.CntW(4), .LongCnt(8), .GapCnt(5)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .level_i    (level_i),
    .short_o    (short_o),
    .long_o     (long_o),
    .double_o   (double_o),
    .held_o     (held_o),
    .event_cnt_o(event_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Present a level for the next posedge and sample 1 time unit after it
  task automatic drive(input logic lv);
    @(negedge clk_i);
    level_i = lv;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i   = 1'b1;
    level_i = 1'b0;
    #2;
    checks++;
    if ({short_o, long_o, double_o, held_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses got=%b want=0000", {short_o, long_o, double_o, held_o});
    end
    checks++;
    if (event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_evcnt got=%0d want=0", event_cnt_o);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b0);
    checks++;
    if ({short_o, long_o, double_o, held_o, event_cnt_o} !== 12'd0) begin
      errors++;
      $display("FAIL reset_release got=%b want=0", {short_o, long_o, double_o, held_o, event_cnt_o});
    end
  endtask

  task automatic test_short;
    logic [7:0] ec0;
    int         other;
    ec0   = event_cnt_o;
    other = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      other += int'(short_o) + int'(long_o) + int'(double_o);
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0);
      checks++;
      if (short_o !== (i == 5)) begin
        errors++;
        $display("FAIL short_pulse R%0d got=%b want=%b", i, short_o, (i == 5));
      end
      other += int'(long_o) + int'(double_o);
    end
    checks++;
    if (other != 0) begin
      errors++;
      $display("FAIL short_no_other got=%0d want=0", other);
    end
    checks++;
    if (event_cnt_o !== ec0 + 8'd1) begin
      errors++;
      $display("FAIL short_evcnt got=%0d want=%0d", event_cnt_o, ec0 + 8'd1);
    end
  endtask

  task automatic test_long;
    logic [7:0] ec0;
    int         bad;
    ec0 = event_cnt_o;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1);
      checks++;
      if (long_o !== (i == 8) || held_o !== (i >= 8)) begin
        errors++;
        $display("FAIL long_hold E%0d got long=%b held=%b want long=%b held=%b",
                 i, long_o, held_o, (i == 8), (i >= 8));
      end
      bad += int'(short_o) + int'(double_o);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0);
      checks++;
      if (held_o !== 1'b0 || short_o !== 1'b0) begin
        errors++;
        $display("FAIL long_release R%0d got held=%b short=%b want 0 0", i, held_o, short_o);
      end
      bad += int'(long_o) + int'(double_o);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL long_no_other got=%0d want=0", bad);
    end
    checks++;
    if (event_cnt_o !== ec0 + 8'd1) begin
      errors++;
      $display("FAIL long_evcnt got=%0d want=%0d", event_cnt_o, ec0 + 8'd1);
    end
  endtask

  task automatic test_double;
    logic [7:0] ec0;
    int         shorts, longs;
    ec0    = event_cnt_o;
    shorts = 0;
    longs  = 0;
    for (int i = 0; i < 3; i++) begin drive(1'b1); shorts += int'(short_o); end
    for (int i = 0; i < 2; i++) begin drive(1'b0); shorts += int'(short_o); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      checks++;
      if (double_o !== (i == 0)) begin
        errors++;
        $display("FAIL double_pulse P2E%0d got=%b want=%b", i, double_o, (i == 0));
      end
      shorts += int'(short_o);
      longs  += int'(long_o);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0);
      shorts += int'(short_o);
      longs  += int'(long_o) + int'(double_o);
    end
    checks++;
    if (shorts != 0 || longs != 0) begin
      errors++;
      $display("FAIL double_no_other got short=%0d other=%0d want 0 0", shorts, longs);
    end
    checks++;
    if (event_cnt_o !== ec0 + 8'd1) begin
      errors++;
      $display("FAIL double_evcnt got=%0d want=%0d", event_cnt_o, ec0 + 8'd1);
    end
  endtask

  task automatic test_boundaries;
    logic [7:0] ec0;
    int         longs, shorts, doubles;
    ec0 = event_cnt_o;
    // 8 high samples: one short of long
    longs = 0; shorts = 0;
    for (int i = 0; i < 8; i++) begin drive(1'b1); longs += int'(long_o); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0);
      longs += int'(long_o);
      if (i == 5) shorts += int'(short_o);
    end
    checks++;
    if (longs != 0 || shorts != 1) begin
      errors++;
      $display("FAIL bnd_high8 got long=%0d short@R5=%0d want 0 1", longs, shorts);
    end
    // 9 high samples: long exactly at E8
    for (int i = 0; i < 9; i++) begin
      drive(1'b1);
      checks++;
      if (long_o !== (i == 8)) begin
        errors++;
        $display("FAIL bnd_high9 E%0d got=%b want=%b", i, long_o, (i == 8));
      end
    end
    for (int i = 0; i < 3; i++) drive(1'b0);
    // Second press sampled at R5 wins over gap expiry
    shorts = 0; doubles = 0;
    for (int i = 0; i < 3; i++) drive(1'b1);
    for (int i = 0; i < 5; i++) begin drive(1'b0); shorts += int'(short_o); end
    drive(1'b1);
    doubles = int'(double_o);
    shorts += int'(short_o);
    for (int i = 0; i < 2; i++) drive(1'b1);
    for (int i = 0; i < 7; i++) begin drive(1'b0); shorts += int'(short_o); end
    checks++;
    if (doubles != 1 || shorts != 0) begin
      errors++;
      $display("FAIL bnd_gap_r5 got double=%0d short=%0d want 1 0", doubles, shorts);
    end
    // Second press at R6: short at R5, then a fresh press from R6
    for (int i = 0; i < 3; i++) drive(1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0);
      checks++;
      if (short_o !== (i == 5)) begin
        errors++;
        $display("FAIL bnd_gap_r6 R%0d got=%b want=%b", i, short_o, (i == 5));
      end
    end
    doubles = 0; shorts = 0;
    for (int i = 0; i < 3; i++) begin drive(1'b1); doubles += int'(double_o); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0);
      if (i == 5) shorts += int'(short_o);
    end
    checks++;
    if (doubles != 0 || shorts != 1) begin
      errors++;
      $display("FAIL bnd_r6_press1 got double=%0d short@R5=%0d want 0 1", doubles, shorts);
    end
    checks++;
    if (event_cnt_o !== ec0 + 8'd5) begin
      errors++;
      $display("FAIL bnd_evcnt got=%0d want=%0d", event_cnt_o, ec0 + 8'd5);
    end
  endtask

  task automatic test_wrap;
    int shorts;
    shorts = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    level_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 0; n < 255; n++) begin
      drive(1'b1);
      for (int i = 0; i < 6; i++) begin drive(1'b0); shorts += int'(short_o); end
    end
    checks++;
    if (shorts != 255) begin
      errors++;
      $display("FAIL wrap_shorts got=%0d want=255", shorts);
    end
    checks++;
    if (event_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255 got=%0d want=255", event_cnt_o);
    end
    drive(1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0);
    checks++;
    if (event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0 got=%0d want=0", event_cnt_o);
    end
  endtask

  task automatic test_reset_hold;
    for (int i = 0; i < 10; i++) drive(1'b1);
    checks++;
    if (held_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_before_rst got=%b want=1", held_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (held_o !== 1'b0 || event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL hold_async_rst got held=%b evcnt=%0d want 0 0", held_o, event_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    // level_i still high: first edge after release starts a new press
    for (int i = 0; i < 9; i++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (long_o !== (i == 8)) begin
        errors++;
        $display("FAIL hold_repress E%0d got=%b want=%b", i, long_o, (i == 8));
      end
    end
    checks++;
    if (held_o !== 1'b1 || event_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL hold_repress_end got held=%b evcnt=%0d want 1 1", held_o, event_cnt_o);
    end
    for (int i = 0; i < 3; i++) drive(1'b0);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundaries();
    test_wrap();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
